// File: rtl/gcd_requester_pkg.sv
// Shared defaults and FSM encoding for the GCD batch requester.
// Imported by the requester top and its operand table.
package gcd_requester_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    REPORT
  } state_t;

endpackage

// File: rtl/gcd_operand_table.sv
// Operand-pair table: DEPTH x {a,b} registers,
// one synchronous write port, one asynchronous read port.
module gcd_operand_table
  import gcd_requester_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wa,
  input  logic [WIDTH-1:0] wb,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] ra,
  output logic [WIDTH-1:0] rb
);

  logic [2*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= {wa, wb};
    end
  end

  assign {ra, rb} = mem[raddr];

endmodule

// File: rtl/gcd_requester.sv
// Batch requester: walks the operand table, issues each pair
// to an external GCD core and reports result or timeout per entry.
module gcd_requester
  import gcd_requester_pkg::*;
#(
  parameter int  WIDTH   = WIDTH_DEF,
  parameter int  DEPTH   = DEPTH_DEF,
  parameter int  TIMEOUT = TIMEOUT_DEF,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [AW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             go,
  input  logic [AW:0]      cnt,
  output logic             busy,
  output logic             batch_done,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_gcd,
  output logic             res_valid,
  output logic [AW-1:0]    res_idx,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_err
);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    last_q, last_d;
  logic [CW-1:0]    wcnt_q, wcnt_d, wnext;
  logic [AW:0]      cnt_sat;
  logic             cap, cap_err;
  logic             zdone_q;
  logic [WIDTH-1:0] tab_a, tab_b;
  logic [WIDTH-1:0] core_a_q, core_b_q;

  gcd_operand_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (load),
    .waddr (load_idx),
    .wa    (load_a),
    .wb    (load_b),
    .raddr (idx_q),
    .ra    (tab_a),
    .rb    (tab_b)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    cap     = 1'b0;
    cap_err = 1'b0;
    wnext   = wcnt_q + 1'b1;
    cnt_sat = (cnt > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cnt;
    unique case (state_q)
      IDLE: begin
        if (go && cnt != '0) begin
          idx_d   = '0;
          last_d  = AW'(cnt_sat - 1'b1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done on the expiry cycle still wins over the timeout
        if (core_done) begin
          cap     = 1'b1;
          state_d = REPORT;
        end else if (wnext == CW'(TIMEOUT)) begin
          cap     = 1'b1;
          cap_err = 1'b1;
          state_d = REPORT;
        end else begin
          wcnt_d = wnext;
        end
      end
      REPORT: begin
        if (idx_q == last_q) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      wcnt_q   <= '0;
      zdone_q  <= 1'b0;
      core_a_q <= '0;
      core_b_q <= '0;
      res_gcd  <= '0;
      res_idx  <= '0;
      res_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      zdone_q <= (state_q == IDLE) && go && (cnt == '0);
      // snapshot isolates the in-flight pair from later table writes
      if (state_q == ISSUE) begin
        core_a_q <= tab_a;
        core_b_q <= tab_b;
      end
      if (cap) begin
        res_gcd <= cap_err ? '0 : core_gcd;
        res_err <= cap_err;
        res_idx <= idx_q;
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign core_start = (state_q == ISSUE);
  assign res_valid  = (state_q == REPORT);
  assign batch_done = zdone_q | (res_valid & (idx_q == last_q));
  assign core_a     = core_start ? tab_a : core_a_q;
  assign core_b     = core_start ? tab_b : core_b_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Scoreboard bench for gcd_requester with a behavioural GCD core
// whose response delay is chosen per request.
module tb_gcd_requester;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int T  = 64;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load = 1'b0;
  logic [AW-1:0] load_idx = '0;
  logic [W-1:0]  load_a = '0;
  logic [W-1:0]  load_b = '0;
  logic          go = 1'b0;
  logic [AW:0]   cnt = '0;
  logic          busy, batch_done, core_start;
  logic [W-1:0]  core_a, core_b;
  logic          core_done = 1'b0;
  logic [W-1:0]  core_gcd = '0;
  logic          res_valid;
  logic [AW-1:0] res_idx;
  logic [W-1:0]  res_gcd;
  logic          res_err;

  always #5 clk = ~clk;

  gcd_requester #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_idx(load_idx),
    .load_a(load_a), .load_b(load_b), .go(go), .cnt(cnt),
    .busy(busy), .batch_done(batch_done), .core_start(core_start),
    .core_a(core_a), .core_b(core_b), .core_done(core_done),
    .core_gcd(core_gcd), .res_valid(res_valid), .res_idx(res_idx),
    .res_gcd(res_gcd), .res_err(res_err)
  );

  typedef struct {
    bit           empty;
    int           idx;
    logic [W-1:0] g;
    bit           err;
    bit           last;
  } exp_t;

  exp_t         expq[$];
  int           dq[$];
  logic [W-1:0] ma[D];
  logic [W-1:0] mb[D];
  int           dly[D];
  int           checks = 0;
  int           errors = 0;
  int           done_seen = 0;
  int           cyc = 0;
  int           spur_at = -1;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  // Behavioural GCD core: answers d cycles into WAIT (0 = never)
  int           c_left = 0;
  bit           c_act = 0;
  int           c_d;
  logic [W-1:0] sa, sb;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      c_act = 0;
      core_done = 1'b0;
      dq.delete();
    end else begin
      core_done = 1'b0;
      if (cyc == spur_at) begin
        core_done = 1'b1;
        core_gcd = 16'd99;
      end
      if (c_act) begin
        c_left--;
        if (c_left == 0) begin
          c_act = 0;
          chk("core_a_stable", 32'(core_a), 32'(sa));
          chk("core_b_stable", 32'(core_b), 32'(sb));
          core_done = 1'b1;
          core_gcd = gcd_f(sa, sb);
        end
      end
      if (core_start) begin
        c_d = (dq.size() > 0) ? dq.pop_front() : 0;
        sa = core_a;
        sb = core_b;
        c_act = (c_d > 0);
        c_left = c_d;
      end
    end
  end

  // Monitor: every result or batch_done pulse consumes one record
  exp_t         e;
  logic [W-1:0] hg;
  logic [AW-1:0] hi;
  logic         he;
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      hg = '0;
      hi = '0;
      he = 1'b0;
    end else begin
      if (res_valid || batch_done) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 32'(res_valid), 32'(0));
          chk("unexpected_done", 32'(batch_done), 32'(0));
        end else begin
          e = expq.pop_front();
          if (e.empty) begin
            chk("empty_valid", 32'(res_valid), 32'(0));
            chk("empty_done", 32'(batch_done), 32'(1));
            chk("empty_busy", 32'(busy), 32'(0));
          end else begin
            chk("res_valid", 32'(res_valid), 32'(1));
            chk("res_idx", 32'(res_idx), 32'(e.idx));
            chk("res_gcd", 32'(res_gcd), 32'(e.g));
            chk("res_err", 32'(res_err), 32'(e.err));
            chk("res_last_done", 32'(batch_done), 32'(e.last));
            chk("res_busy", 32'(busy), 32'(1));
          end
        end
        if (batch_done) done_seen++;
      end
      if (res_valid) begin
        hg = res_gcd;
        hi = res_idx;
        he = res_err;
      end else begin
        chk("res_hold", 32'({res_gcd, res_idx, res_err}), 32'({hg, hi, he}));
      end
    end
  end

  task automatic do_load(input int i, input int a, input int b);
    @(negedge clk);
    load = 1'b1;
    load_idx = AW'(i);
    load_a = W'(a);
    load_b = W'(b);
    ma[i] = W'(a);
    mb[i] = W'(b);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push_batch(input int c);
    int n;
    bit er;
    exp_t x;
    n = (c > D) ? D : c;
    if (n == 0) begin
      x = '{1'b1, 0, '0, 1'b0, 1'b1};
      expq.push_back(x);
    end
    for (int i = 0; i < n; i++) begin
      er = (dly[i] == 0) || (dly[i] > T);
      x = '{1'b0, i, er ? '0 : gcd_f(ma[i], mb[i]), er, i == n - 1};
      expq.push_back(x);
      dq.push_back(dly[i]);
    end
  endtask

  task automatic go_pulse(input int c);
    @(negedge clk);
    go = 1'b1;
    cnt = (AW+1)'(c);
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int tgt);
    int n;
    n = 0;
    while (done_seen < tgt) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 3000) break;
    end
    chk("batch_done_seen", 32'(done_seen >= tgt), 32'(1));
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!core_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("core_start_seen", 32'(core_start), 32'(1));
  endtask

  task automatic run_batch(input int c);
    int tgt;
    push_batch(c);
    tgt = done_seen + 1;
    go_pulse(c);
    wait_done(tgt);
    repeat (T + 4) @(negedge clk);
    chk("exp_drained", 32'(expq.size()), 32'(0));
  endtask

  task automatic chk_outs_zero(input string n);
    chk({n, "_busy"}, 32'(busy), 32'(0));
    chk({n, "_done"}, 32'(batch_done), 32'(0));
    chk({n, "_start"}, 32'(core_start), 32'(0));
    chk({n, "_valid"}, 32'(res_valid), 32'(0));
    chk({n, "_err"}, 32'(res_err), 32'(0));
    chk({n, "_core_a"}, 32'(core_a), 32'(0));
    chk({n, "_core_b"}, 32'(core_b), 32'(0));
    chk({n, "_res_gcd"}, 32'(res_gcd), 32'(0));
    chk({n, "_res_idx"}, 32'(res_idx), 32'(0));
  endtask

  initial begin
    int tgt;
    int r;
    int m;
    for (int i = 0; i < D; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      dly[i] = 1;
    end
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    do_load(0, 18, 12);
    do_load(1, 1000, 160);
    do_load(2, 3, 15);
    dly[0] = 3; dly[1] = 5; dly[2] = 2;
    run_batch(3);

    do_load(0, 9, 6);
    dly[0] = 0;
    run_batch(1);

    do_load(0, 10, 15);
    dly[0] = T;
    run_batch(1);

    do_load(0, 14, 21);
    dly[0] = T + 1;
    run_batch(1);

    push_batch(0);
    tgt = done_seen + 1;
    go_pulse(0);
    for (int k = 0; k < 3; k++) begin
      chk("zero_no_start", 32'(core_start), 32'(0));
      chk("zero_busy", 32'(busy), 32'(0));
      @(negedge clk);
    end
    wait_done(tgt);

    spur_at = cyc + 2;
    repeat (6) @(negedge clk);
    chk("spurious_idle_busy", 32'(busy), 32'(0));

    do_load(0, 18, 12);
    do_load(1, 8, 12);
    dly[0] = 8; dly[1] = 2;
    push_batch(2);
    tgt = done_seen + 1;
    go_pulse(2);
    wait_start();
    @(negedge clk);
    load = 1'b1; load_idx = '0; load_a = 16'd50; load_b = 16'd75;
    go = 1'b1; cnt = 3'd1;
    ma[0] = 16'd50; mb[0] = 16'd75;
    @(negedge clk);
    load = 1'b0; go = 1'b0;
    wait_done(tgt);
    repeat (T + 4) @(negedge clk);
    chk("second_go_ignored", 32'(expq.size()), 32'(0));

    for (int b = 0; b < 9; b++) begin
      for (int i = 0; i < D; i++) begin
        m = $urandom_range(1, 20);
        do_load(i, m * $urandom_range(0, 50), m * $urandom_range(0, 50));
        r = $urandom_range(0, 9);
        dly[i] = (r == 0) ? 0 : (r == 1) ? T : (r == 2) ? T + 1
               : $urandom_range(1, 12);
      end
      run_batch((b == 0) ? 7 : $urandom_range(0, 7));
    end

    do_load(0, 33, 22);
    do_load(1, 5, 5);
    dly[0] = 0; dly[1] = 0;
    push_batch(2);
    go_pulse(2);
    wait_start();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("midwait_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    do_load(0, 7, 21);
    dly[0] = 4;
    run_batch(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
